arb_requester: RTL and testbench
================================

Name: arb_requester

Overview:
- Master-side agent for the three-master round-robin arbiter; one instance sits in front of each master.
- Accepts transfer jobs (beat count) over a valid/ready interface.
- Raises req, waits for gnt, then issues one beat per granted cycle.
- Drops req after the last beat and waits for gnt to fall before accepting the next job, so the arbiter sees a clean release.

Parameters:
- LEN_W, 8, width of the job length field; max job = 2^LEN_W-1 beats.
- TIMEOUT, 64, grant-wait limit in cycles. Used only with ARB_REQ_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- job_valid  in  1  job offered
- job_ready  out  1  block can accept a job (high only in IDLE)
- job_len  in  LEN_W  beats in job, sampled when job_valid && job_ready
- req  out  1  request to arbiter (registered)
- gnt  in  1  grant from arbiter
- beat_valid  out  1  a beat is issued this cycle
- beat_idx  out  LEN_W  index of current beat, 0..len-1; valid with beat_valid
- done  out  1  one-cycle pulse, job completed and resource released
- busy  out  1  state != IDLE
- timeout_err  out  1  one-cycle pulse, grant wait aborted

Behaviour:
- Reset state:
  - state=IDLE; req=0, done=0, timeout_err=0, beat counter=0, wait counter=0.
  - job_ready=1 and busy=0 from the first cycle after reset.
- States: IDLE, REQ, XFER, REL.
- IDLE:
  - job_ready=1.
  - Accept on job_valid && job_ready. Latch len; clear counters.
  - len!=0: go to REQ, req<=1.
  - len==0: stay in IDLE, req stays 0, pulse done next cycle. No arbiter activity.
  - gnt is ignored in IDLE.
- REQ:
  - req=1.
  - On gnt=1: go to XFER. The same cycle counts as beat 0 (beat_valid=1, beat_idx=0).
- XFER:
  - req=1.
  - beat_valid = gnt, combinational from state, gnt and counter.
  - On a beat the counter increments. If gnt drops unexpectedly, hold state and counter; no beat is issued.
  - On the beat where beat_idx==len-1: go to REL, req<=0.
  - A single-beat job takes this path from REQ directly to REL.
- REL:
  - req=0, beat_valid=0.
  - Any gnt=1 here is the arbiter's release cycle and carries no beat.
  - When gnt==0 is sampled: go to IDLE, done<=1.
- Latency with the arbiter free and no other requesters (accept at cycle T, len=N≥1):
  - req high T+1..T+N+1.
  - gnt high T+2..T+N+2.
  - beats T+2..T+N+1.
  - done and job_ready at T+N+4; a back-to-back job can be accepted at T+N+4.
- Counters:
  - Beat counter is LEN_W bits and never wraps, because len ≤ 2^LEN_W-1 and the count stops at len-1.
  - Wait counter is ceil(log2(TIMEOUT+1)) bits and saturates.
- Reset mid-operation: returns to IDLE with req=0 within one cycle. No done or timeout_err pulse is generated.
- Only one of done and timeout_err can assert in any cycle.

Optional Feature:
- Macro: ARB_REQ_TIMEOUT_EN.
- Defined:
  - In REQ, the wait counter increments each cycle gnt=0.
  - When it reaches TIMEOUT with gnt=0: req<=0, state<=IDLE, timeout_err pulses next cycle, no done.
  - If gnt=1 in the cycle the count reaches TIMEOUT, the grant wins and the block goes to XFER normally.
- Not defined:
  - REQ waits indefinitely; no wait counter is built.
  - timeout_err is tied 0; the port is always present.

Test Plan:
- Single job, len=4, arbiter free:
  - Expected: req rises at T+1.
  - Four beats with beat_idx 0,1,2,3 at T+2..T+5.
  - req falls at T+6.
  - done pulse at T+8; job_ready=1 at T+8.
- len=0:
  - Expected: req never asserts, done pulses at T+1, no beats.
- Contention: masters 0 and 2 both request len=3, arbiter priority favours 0:
  - Expected: master 2 holds req through master 0's three beats plus release.
  - Master 2 then gets three beats.
  - No cycle with both masters' beat_valid=1.
- gnt glitch in XFER, len=5: force gnt=0 for 2 cycles after beat 1.
  - Expected: no beats during the glitch; beats resume at idx 2.
  - Five beats total; done asserts once.
- Reset asserted during XFER at beat 2:
  - Expected: next cycle req=0, busy=0, job_ready=1, no done pulse.
- ARB_REQ_TIMEOUT_EN, TIMEOUT=8, gnt held 0:
  - Expected: req high for 8 cycles, then req=0 and timeout_err pulses once, no done.
  - Repeat with gnt=1 on cycle 8: transfer proceeds and timeout_err stays 0.

Source files
------------

// File: rtl/arb_requester.sv
// Master-side requester for a round-robin arbiter: takes a beat-count job, requests, streams beats on grant, releases cleanly.
// Optional grant-wait timeout is built when ARB_REQ_TIMEOUT_EN is defined.
module arb_requester #(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [LEN_W-1:0] job_len,
    output logic             req,
    input  logic             gnt,
    output logic             beat_valid,
    output logic [LEN_W-1:0] beat_idx,
    output logic             done,
    output logic             busy,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        REL  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d;
    logic               done_q, done_d;
    logic               last_beat;

`ifdef ARB_REQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [WAIT_W-1:0]  wait_inc;
    logic               terr_q, terr_d;

    // Saturating increment so the counter can never wrap back below the limit.
    assign wait_inc = (wait_q == WAIT_W'(TIMEOUT)) ? wait_q : wait_q + 1'b1;
`endif

    assign last_beat = (cnt_q == len_q - 1'b1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        done_d  = 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
        wait_d  = wait_q;
        terr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (job_valid) begin
                    len_d = job_len;
                    cnt_d = '0;
`ifdef ARB_REQ_TIMEOUT_EN
                    wait_d = '0;
`endif
                    // A zero-length job completes without touching the arbiter.
                    if (job_len != '0) begin
                        state_d = REQ;
                        req_d   = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            REQ, XFER: begin
                if (gnt) begin
                    if (last_beat) begin
                        state_d = REL;
                        req_d   = 1'b0;
                    end else begin
                        state_d = XFER;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
`ifdef ARB_REQ_TIMEOUT_EN
                else if (state_q == REQ) begin
                    wait_d = wait_inc;
                    if (wait_inc == WAIT_W'(TIMEOUT)) begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                        terr_d  = 1'b1;
                    end
                end
`endif
            end
            REL: begin
                // Wait for the arbiter to drop its grant before reporting completion.
                if (!gnt) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            done_q  <= done_d;
        end
    end

`ifdef ARB_REQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= '0;
            terr_q <= 1'b0;
        end else begin
            wait_q <= wait_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign job_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign req        = req_q;
    assign done       = done_q;
    assign beat_valid = gnt && ((state_q == REQ) || (state_q == XFER));
    assign beat_idx   = cnt_q;

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: per-cycle vector table on one requester, plus contention and max-length sequences.
module tb_arb_requester;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             jv0 = 1'b0, jv2 = 1'b0;
    logic [LEN_W-1:0] len0 = '0, len2 = '0;
    logic             gnt_tb = 1'b0;
    logic             arb_mode = 1'b0;
    logic             gnt0, gnt2;

    logic             rdy0, req0, bv0, done0, busy0, terr0;
    logic             rdy2, req2, bv2, done2, busy2, terr2;
    logic [LEN_W-1:0] idx0, idx2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Fixed-priority arbiter model (master 0 first), registered grant, one release cycle.
    logic [1:0] owner_q;
    always @(posedge clk) begin
        if (rst) owner_q <= 2'd0;
        else begin
            case (owner_q)
                2'd1:    if (!req0) owner_q <= 2'd0;
                2'd2:    if (!req2) owner_q <= 2'd0;
                default: if (req0) owner_q <= 2'd1; else if (req2) owner_q <= 2'd2;
            endcase
        end
    end

    assign gnt0 = arb_mode ? (owner_q == 2'd1) : gnt_tb;
    assign gnt2 = arb_mode ? (owner_q == 2'd2) : 1'b0;

    arb_requester #(.LEN_W(LEN_W), .TIMEOUT(8)) u0 (
        .clk(clk), .rst(rst), .job_valid(jv0), .job_ready(rdy0), .job_len(len0),
        .req(req0), .gnt(gnt0), .beat_valid(bv0), .beat_idx(idx0),
        .done(done0), .busy(busy0), .timeout_err(terr0)
    );

    arb_requester #(.LEN_W(LEN_W), .TIMEOUT(8)) u2 (
        .clk(clk), .rst(rst), .job_valid(jv2), .job_ready(rdy2), .job_len(len2),
        .req(req2), .gnt(gnt2), .beat_valid(bv2), .beat_idx(idx2),
        .done(done2), .busy(busy2), .timeout_err(terr2)
    );

    typedef struct {
        logic             r;
        logic             jv;
        logic [LEN_W-1:0] len;
        logic             g;
        logic             e_req;
        logic             e_bv;
        logic [LEN_W-1:0] e_idx;
        logic             e_done;
        logic             e_busy;
        logic             e_terr;
    } vec_t;

    vec_t vt[$];

    task automatic v(input logic r, input logic jv, input int len, input logic g,
                     input logic e_req, input logic e_bv, input int e_idx,
                     input logic e_done, input logic e_busy, input logic e_terr);
        vec_t x;
        x.r = r; x.jv = jv; x.len = LEN_W'(len); x.g = g;
        x.e_req = e_req; x.e_bv = e_bv; x.e_idx = LEN_W'(e_idx);
        x.e_done = e_done; x.e_busy = e_busy; x.e_terr = e_terr;
        vt.push_back(x);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else
            $display("ok   %s: %0d", name, act);
    endtask

    initial begin
        int beats0, beats2, overlap, drops2, dn0, dn2, ierr, last0, first2, started2;
        int beats, lastidx, seen_done, terr_seen;

        // ---- table fill: (rst, jv, len, gnt) -> (req, bv, idx, done, busy, terr)
        v(0,0,0,0, 0,0,0,0,0,0);                 // reset state
        v(0,0,0,1, 0,0,0,0,0,0);                 // gnt ignored in IDLE
        // len=4, arbiter free
        v(0,1,4,0, 0,0,0,0,0,0);
        v(0,0,0,0, 1,0,0,0,1,0);
        for (int i = 0; i < 4; i++) v(0,0,0,1, 1,1,i,0,1,0);
        v(0,0,0,1, 0,0,0,0,1,0);
        v(0,0,0,0, 0,0,0,0,1,0);
        v(0,1,0,0, 0,0,0,1,0,0);                 // done at T+8, back-to-back len=0 accepted
        v(0,0,0,0, 0,0,0,1,0,0);                 // len=0 done one cycle later
        v(0,0,0,0, 0,0,0,0,0,0);
        // len=1
        v(0,1,1,0, 0,0,0,0,0,0);
        v(0,0,0,0, 1,0,0,0,1,0);
        v(0,0,0,1, 1,1,0,0,1,0);
        v(0,0,0,1, 0,0,0,0,1,0);
        v(0,0,0,0, 0,0,0,0,1,0);
        v(0,0,0,0, 0,0,0,1,0,0);
        // len=5 with a 2-cycle grant glitch after beat 1
        v(0,1,5,0, 0,0,0,0,0,0);
        v(0,0,0,0, 1,0,0,0,1,0);
        v(0,0,0,1, 1,1,0,0,1,0);
        v(0,0,0,1, 1,1,1,0,1,0);
        v(0,0,0,0, 1,0,0,0,1,0);
        v(0,0,0,0, 1,0,0,0,1,0);
        for (int i = 2; i < 5; i++) v(0,0,0,1, 1,1,i,0,1,0);
        v(0,0,0,1, 0,0,0,0,1,0);
        v(0,0,0,0, 0,0,0,0,1,0);
        v(0,0,0,0, 0,0,0,1,0,0);
        v(0,0,0,0, 0,0,0,0,0,0);
        // reset during XFER at beat 2
        v(0,1,5,0, 0,0,0,0,0,0);
        v(0,0,0,0, 1,0,0,0,1,0);
        v(0,0,0,1, 1,1,0,0,1,0);
        v(0,0,0,1, 1,1,1,0,1,0);
        v(1,0,0,1, 1,1,2,0,1,0);
        v(0,0,0,1, 0,0,0,0,0,0);
        v(0,0,0,0, 0,0,0,0,0,0);
`ifdef ARB_REQ_TIMEOUT_EN
        // TIMEOUT=8, gnt held low: 8 request cycles then a single timeout pulse
        v(0,1,3,0, 0,0,0,0,0,0);
        for (int i = 0; i < 8; i++) v(0,0,0,0, 1,0,0,0,1,0);
        v(0,0,0,0, 0,0,0,0,0,1);
        v(0,0,0,0, 0,0,0,0,0,0);
        // grant arrives on the 8th wait cycle: grant wins
        v(0,1,2,0, 0,0,0,0,0,0);
        for (int i = 0; i < 7; i++) v(0,0,0,0, 1,0,0,0,1,0);
        v(0,0,0,1, 1,1,0,0,1,0);
        v(0,0,0,1, 1,1,1,0,1,0);
        v(0,0,0,1, 0,0,0,0,1,0);
        v(0,0,0,0, 0,0,0,0,1,0);
        v(0,0,0,0, 0,0,0,1,0,0);
        v(0,0,0,0, 0,0,0,0,0,0);
`else
        // no timeout built: a long grant wait just continues
        v(0,1,2,0, 0,0,0,0,0,0);
        for (int i = 0; i < 12; i++) v(0,0,0,0, 1,0,0,0,1,0);
        v(0,0,0,1, 1,1,0,0,1,0);
        v(0,0,0,1, 1,1,1,0,1,0);
        v(0,0,0,1, 0,0,0,0,1,0);
        v(0,0,0,0, 0,0,0,0,1,0);
        v(0,0,0,0, 0,0,0,1,0,0);
`endif

        repeat (3) @(posedge clk);

        // ---- apply table
        foreach (vt[i]) begin
            @(negedge clk);
            rst = vt[i].r; jv0 = vt[i].jv; len0 = vt[i].len; gnt_tb = vt[i].g;
            #1;
            total++;
            if (req0 !== vt[i].e_req || bv0 !== vt[i].e_bv ||
                (vt[i].e_bv && idx0 !== vt[i].e_idx) || done0 !== vt[i].e_done ||
                busy0 !== vt[i].e_busy || rdy0 !== !vt[i].e_busy || terr0 !== vt[i].e_terr) begin
                bad++;
                $display("FAIL vec%0d: got req=%b bv=%b idx=%0d done=%b busy=%b rdy=%b terr=%b expected req=%b bv=%b idx=%0d done=%b busy=%b rdy=%b terr=%b",
                         i, req0, bv0, idx0, done0, busy0, rdy0, terr0,
                         vt[i].e_req, vt[i].e_bv, vt[i].e_idx, vt[i].e_done,
                         vt[i].e_busy, !vt[i].e_busy, vt[i].e_terr);
            end else
                $display("ok   vec%0d", i);
        end
        @(negedge clk);
        rst = 1'b0; jv0 = 1'b0; gnt_tb = 1'b0;

        // ---- contention: masters 0 and 2 both request len=3
        @(negedge clk);
        arb_mode = 1'b1; jv0 = 1'b1; len0 = 8'd3; jv2 = 1'b1; len2 = 8'd3;
        beats0 = 0; beats2 = 0; overlap = 0; drops2 = 0; dn0 = 0; dn2 = 0;
        ierr = 0; last0 = -1; first2 = -1; started2 = 0;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) begin
                @(negedge clk);
                jv0 = 1'b0; jv2 = 1'b0;
            end
            #1;
            if (bv0 && bv2) overlap++;
            if (bv0) begin
                if (idx0 != LEN_W'(beats0)) ierr++;
                beats0++; last0 = c;
            end
            if (bv2) begin
                if (idx2 != LEN_W'(beats2)) ierr++;
                if (first2 < 0) first2 = c;
                beats2++;
            end
            if (req2) started2 = 1;
            if (started2 && beats2 == 0 && !req2) drops2++;
            if (done0) dn0++;
            if (done2) dn2++;
        end
        chk("cont_beats_m0", beats0, 3);
        chk("cont_beats_m2", beats2, 3);
        chk("cont_overlap", overlap, 0);
        chk("cont_idx_errors", ierr, 0);
        chk("cont_m2_req_drops", drops2, 0);
        chk("cont_m2_after_release", (first2 >= last0 + 3) ? 1 : 0, 1);
        chk("cont_done_m0", dn0, 1);
        chk("cont_done_m2", dn2, 1);

        // ---- maximum length job, grant held high
        @(negedge clk);
        arb_mode = 1'b0; gnt_tb = 1'b1; jv0 = 1'b1; len0 = 8'd255;
        beats = 0; lastidx = -1; ierr = 0; seen_done = 0; terr_seen = 0;
        for (int c = 0; c < 400 && seen_done == 0; c++) begin
            if (c > 0) begin
                @(negedge clk);
                jv0 = 1'b0;
                if (req0 == 1'b0 && beats == 255) gnt_tb = 1'b0;
            end
            #1;
            if (bv0) begin
                if (idx0 != LEN_W'(beats)) ierr++;
                lastidx = int'(idx0);
                beats++;
            end
            if (done0) seen_done = 1;
            if (terr0) terr_seen++;
        end
        chk("max_beats", beats, 255);
        chk("max_last_idx", lastidx, 254);
        chk("max_idx_errors", ierr, 0);
        chk("max_done_seen", seen_done, 1);
        chk("max_no_timeout", terr_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
